// File: rtl/bitbang_host_link.sv
// bitbang_host_link
//   Bit-bang slave between the host pin interface and the hashing cores.
//   The host clocks a work unit in on rxc (LSB first per byte) and frames it
//   with rxtxr. A complete frame is presented on work_data with a one-cycle
//   work_valid. Result words from the cores are queued in a small FIFO and
//   shifted back to the host on txc, one start bit (txd=1) per byte.
//
// Optional build macro: RX_CHECKSUM_EN
//   When defined, a frame carries one extra trailing byte that must equal the
//   XOR of all payload bytes. A mismatch pulses rx_crc_err instead of
//   work_valid. When undefined, rx_crc_err is tied low.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   rxd, rxc, rxtxr   host RX data, RX strobe, frame strobe (asynchronous)
//   txc, txd          host TX strobe (asynchronous), serial data to host
//   work_data/_valid  last accepted work unit, one-cycle update pulse
//   result_data/_valid  nonce from the cores and its push strobe
//   fifo_level        occupied result-queue entries
//   result_overflow   sticky, a result was dropped on a full queue
//   rx_overrun        sticky until next frame strobe, too many bytes in frame
//   rx_crc_err        one-cycle pulse on checksum mismatch
module bitbang_host_link #(
  parameter int RX_BYTES    = 64,
  parameter int TX_BYTES    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             rxd,
  input  logic                             rxc,
  input  logic                             rxtxr,
  input  logic                             txc,
  output logic                             txd,
  output logic [RX_BYTES*8-1:0]            work_data,
  output logic                             work_valid,
  input  logic [TX_BYTES*8-1:0]            result_data,
  input  logic                             result_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             result_overflow,
  output logic                             rx_overrun,
  output logic                             rx_crc_err
);

`ifdef RX_CHECKSUM_EN
  localparam int RX_FRAME = RX_BYTES + 1;
`else
  localparam int RX_FRAME = RX_BYTES;
`endif
  localparam int BCNT_W = $clog2(RX_FRAME + 1);
  localparam int TXB_W  = (TX_BYTES > 1) ? $clog2(TX_BYTES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {HUNT, BITS} tx_state_t;

  // ---------------------------------------------------------------- pin sync
  logic [SYNC_STAGES-1:0] rxd_s, rxc_s, rxtxr_s, txc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s   <= '0;
      rxc_s   <= '0;
      rxtxr_s <= '0;
      txc_s   <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      rxd_s   <= {rxd_s[SYNC_STAGES-2:0], rxd};
      rxc_s   <= {rxc_s[SYNC_STAGES-2:0], rxc};
      rxtxr_s <= {rxtxr_s[SYNC_STAGES-2:0], rxtxr};
      txc_s   <= {txc_s[SYNC_STAGES-2:0], txc};
    end
  end

  // Rising edge: newer of the last two stages high, older still low.
  logic rxc_rise, rxtxr_rise, txc_rise, rxd_bit;
  assign rxc_rise   = rxc_s[SYNC_STAGES-2]   & ~rxc_s[SYNC_STAGES-1];
  assign rxtxr_rise = rxtxr_s[SYNC_STAGES-2] & ~rxtxr_s[SYNC_STAGES-1];
  assign txc_rise   = txc_s[SYNC_STAGES-2]   & ~txc_s[SYNC_STAGES-1];
  // The host holds rxd well beyond the synchroniser depth around rxc.
  assign rxd_bit    = rxd_s[SYNC_STAGES-1];

  // --------------------------------------------------------------------- RX
  logic [7:0]            byte_sr;
  logic [7:0]            new_sr;
  logic [2:0]            bit_cnt;
  logic [BCNT_W-1:0]     byte_cnt;
  logic [RX_BYTES*8-1:0] rx_sr;
`ifdef RX_CHECKSUM_EN
  logic [7:0]            csum;
  logic [7:0]            chk_byte;
`endif

  assign new_sr = {rxd_bit, byte_sr[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_sr    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      rx_sr      <= '0;
      work_data  <= '0;
      work_valid <= 1'b0;
      rx_overrun <= 1'b0;
`ifdef RX_CHECKSUM_EN
      csum       <= '0;
      chk_byte   <= '0;
      rx_crc_err <= 1'b0;
`endif
    end else begin
      work_valid <= 1'b0;
`ifdef RX_CHECKSUM_EN
      rx_crc_err <= 1'b0;
`endif
      // Frame strobe has priority: a coincident rxc bit is dropped.
      if (rxtxr_rise) begin
        if (!rx_overrun && byte_cnt == BCNT_W'(RX_FRAME) && bit_cnt == 3'd0) begin
`ifdef RX_CHECKSUM_EN
          if (chk_byte == csum) begin
            work_data  <= rx_sr;
            work_valid <= 1'b1;
          end else begin
            rx_crc_err <= 1'b1;
          end
`else
          work_data  <= rx_sr;
          work_valid <= 1'b1;
`endif
        end
        bit_cnt    <= '0;
        byte_cnt   <= '0;
        rx_overrun <= 1'b0;
`ifdef RX_CHECKSUM_EN
        csum       <= '0;
`endif
      end else if (rxc_rise) begin
        byte_sr <= new_sr;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          if (byte_cnt == BCNT_W'(RX_FRAME)) begin
            rx_overrun <= 1'b1;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
`ifdef RX_CHECKSUM_EN
            if (byte_cnt == BCNT_W'(RX_BYTES)) begin
              chk_byte <= new_sr;
            end else begin
              rx_sr <= {rx_sr[RX_BYTES*8-9:0], new_sr};
              csum  <= csum ^ new_sr;
            end
`else
            rx_sr <= {rx_sr[RX_BYTES*8-9:0], new_sr};
`endif
          end
        end
      end
    end
  end

`ifndef RX_CHECKSUM_EN
  assign rx_crc_err = 1'b0;
`endif

  // ------------------------------------------------------------ result FIFO
  logic [TX_BYTES*8-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      count;
  logic                  pop, push_ok;

  tx_state_t             tx_state;
  logic [TXB_W-1:0]      byte_idx;
  logic [2:0]            bit_idx;
  logic [TX_BYTES*8-1:0] tx_word;
  logic [TX_BYTES*8-1:0] tx_shift;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop happens only at the start of a new word; it sees the queue state
  // from before any push in the same cycle.
  assign pop     = txc_rise && !rxtxr_rise && tx_state == HUNT &&
                   byte_idx == '0 && count != '0;
  assign push_ok = result_valid && (count != LVL_W'(FIFO_DEPTH) || pop);

  // NOTE: the queue storage carries no reset; occupancy is tracked by the
  // reset pointers/count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= result_data;
  end

  // Current byte aligned to the top so bytes go out MSB byte first.
  assign tx_shift = tx_word << {byte_idx, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      result_overflow <= 1'b0;
      tx_state        <= HUNT;
      byte_idx        <= '0;
      bit_idx         <= '0;
      tx_word         <= '0;
      txd             <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop)     rd_ptr <= ptr_next(rd_ptr);
      count <= count + LVL_W'(push_ok) - LVL_W'(pop);
      if (result_valid && !push_ok) result_overflow <= 1'b1;

      if (rxtxr_rise) begin
        // New frame aborts any word in flight; txd keeps its level.
        tx_state <= HUNT;
        byte_idx <= '0;
        bit_idx  <= '0;
      end else if (txc_rise) begin
        case (tx_state)
          HUNT: begin
            if (byte_idx != '0) begin
              txd      <= 1'b1;
              tx_state <= BITS;
            end else if (pop) begin
              tx_word  <= mem[rd_ptr];
              txd      <= 1'b1;
              tx_state <= BITS;
            end else begin
              txd <= 1'b0;
            end
          end
          BITS: begin
            txd     <= tx_shift[TX_BYTES*8-8 + int'(bit_idx)];
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              tx_state <= HUNT;
              byte_idx <= (byte_idx == TXB_W'(TX_BYTES - 1)) ? '0 : byte_idx + 1'b1;
            end
          end
          default: tx_state <= HUNT;
        endcase
      end
    end
  end

  assign fifo_level = count;

endmodule
